dds_cfg_ctrl: RTL and testbench

Front-panel configuration controller for the DDS function generator. It takes single-cycle pulses from the debounced push-button blocks (MODE, UP, DOWN) and maintains working settings for frequency, amplitude and waveform. It computes the phase-accumulator tuning word and transfers each new configuration to the DDS datapath through a valid/ready handshake. It sits between the button debouncers and the phase accumulator / waveform LUT / amplitude scaler.

---
 rtl/dds_cfg_ctrl.sv | 139 +++++++++++++
 tb/tb_dds_cfg_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_cfg_ctrl.sv
// rtl/dds_cfg_ctrl.sv - front-panel DDS configuration controller with tuning-word calc and valid/ready transfer
module dds_cfg_ctrl #(
  parameter int ACC_W    = 32,
  parameter int FREQ_W   = 10,
  parameter int FREQ_MAX = 1000,
  parameter int FREQ_RST = 1,
  parameter int TW_STEP  = 179
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             iBtnMode,
  input  logic             iBtnUp,
  input  logic             iBtnDown,
  input  logic             iCfgReady,
  output logic             oCfgValid,
  output logic [ACC_W-1:0] oTuneWord,
  output logic [1:0]       oWaveSel,
  output logic [2:0]       oAmpSel,
  output logic [1:0]       oEditSel
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  localparam logic [FREQ_W-1:0] FREQ_TOP  = FREQ_W'(FREQ_MAX);
  localparam logic [FREQ_W-1:0] FREQ_ONE  = FREQ_W'(1);
  localparam logic [FREQ_W-1:0] FREQ_INIT = FREQ_W'(FREQ_RST);
  localparam logic [ACC_W-1:0]  TW_STEP_W = ACC_W'(TW_STEP);

  logic [1:0]        state_q, state_d;
  logic [1:0]        edit_q, edit_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [2:0]        amp_q, amp_d;
  logic [1:0]        wave_q, wave_d;
  logic              dirty_q, dirty_d;
  logic              valid_q, valid_d;
  logic [ACC_W-1:0]  tune_q, tune_d;
  logic [1:0]        wave_out_q, wave_out_d;
  logic [2:0]        amp_out_q, amp_out_d;
  logic              up_ok, dn_ok;

  // MODE masks UP/DOWN for the cycle; simultaneous UP and DOWN cancel out.
  assign up_ok = !iBtnMode && iBtnUp && !iBtnDown;
  assign dn_ok = !iBtnMode && iBtnDown && !iBtnUp;

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    freq_d     = freq_q;
    amp_d      = amp_q;
    wave_d     = wave_q;
    dirty_d    = dirty_q;
    valid_d    = valid_q;
    tune_d     = tune_q;
    wave_out_d = wave_out_q;
    amp_out_d  = amp_out_q;

    if (iBtnMode) begin
      edit_d = (edit_q == 2'd2) ? 2'd0 : edit_q + 2'd1;
    end

    if (up_ok || dn_ok) begin
      case (edit_q)
        2'd0: begin
          if (up_ok && freq_q < FREQ_TOP) freq_d = freq_q + FREQ_ONE;
          else if (dn_ok && freq_q > FREQ_ONE) freq_d = freq_q - FREQ_ONE;
        end
        2'd1: begin
          if (up_ok && amp_q != 3'd7) amp_d = amp_q + 3'd1;
          else if (dn_ok && amp_q != 3'd0) amp_d = amp_q - 3'd1;
        end
        default: wave_d = up_ok ? wave_q + 2'd1 : wave_q - 2'd1;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          state_d = CALC;
          dirty_d = 1'b0;
        end
      end
      CALC: begin
        tune_d     = ACC_W'(freq_q) * TW_STEP_W;
        wave_out_d = wave_q;
        amp_out_d  = amp_q;
        valid_d    = 1'b1;
        state_d    = VALID;
      end
      VALID: begin
        if (iCfgReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // An accepted edit wins over the IDLE clear so it is never lost.
    if (up_ok || dn_ok) dirty_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      edit_q     <= 2'd0;
      freq_q     <= FREQ_INIT;
      amp_q      <= 3'd7;
      wave_q     <= 2'd0;
      dirty_q    <= 1'b1;
      valid_q    <= 1'b0;
      tune_q     <= '0;
      wave_out_q <= 2'd0;
      amp_out_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      edit_q     <= edit_d;
      freq_q     <= freq_d;
      amp_q      <= amp_d;
      wave_q     <= wave_d;
      dirty_q    <= dirty_d;
      valid_q    <= valid_d;
      tune_q     <= tune_d;
      wave_out_q <= wave_out_d;
      amp_out_q  <= amp_out_d;
    end
  end

  assign oCfgValid = valid_q;
  assign oTuneWord = tune_q;
  assign oWaveSel  = wave_out_q;
  assign oAmpSel   = amp_out_q;
  assign oEditSel  = edit_q;

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// tb/tb_dds_cfg_ctrl.sv - table-driven and sequence checks for dds_cfg_ctrl
module tb_dds_cfg_ctrl;

  logic        CLK;
  logic        RESETn;
  logic        iBtnMode, iBtnUp, iBtnDown, iCfgReady;
  logic        oCfgValid;
  logic [31:0] oTuneWord;
  logic [1:0]  oWaveSel;
  logic [2:0]  oAmpSel;
  logic [1:0]  oEditSel;

  int n_pass;
  int n_total;

  typedef struct {
    logic        m, u, d, r;
    logic        valid;
    logic [31:0] tune;
    logic [1:0]  wave;
    logic [2:0]  amp;
    logic [1:0]  edit;
  } vec_t;

  vec_t vecs[$];

  dds_cfg_ctrl dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .iBtnMode  (iBtnMode),
    .iBtnUp    (iBtnUp),
    .iBtnDown  (iBtnDown),
    .iCfgReady (iCfgReady),
    .oCfgValid (oCfgValid),
    .oTuneWord (oTuneWord),
    .oWaveSel  (oWaveSel),
    .oAmpSel   (oAmpSel),
    .oEditSel  (oEditSel)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic add(input logic m, input logic u, input logic d, input logic r,
                     input logic v, input logic [31:0] t, input logic [1:0] w,
                     input logic [2:0] a, input logic [1:0] e);
    vec_t x;
    x.m = m; x.u = u; x.d = d; x.r = r;
    x.valid = v; x.tune = t; x.wave = w; x.amp = a; x.edit = e;
    vecs.push_back(x);
  endtask

  task automatic step(input logic m, input logic u, input logic d, input logic r);
    iBtnMode = m; iBtnUp = u; iBtnDown = d; iCfgReady = r;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_all(input string name, input logic v, input logic [31:0] t,
                           input logic [1:0] w, input logic [2:0] a, input logic [1:0] e);
    n_total++;
    if (oCfgValid === v && oTuneWord === t && oWaveSel === w && oAmpSel === a && oEditSel === e)
      n_pass++;
    else
      $display("FAIL %s: got valid=%0b tune=%0d wave=%0d amp=%0d edit=%0d, want valid=%0b tune=%0d wave=%0d amp=%0d edit=%0d",
               name, oCfgValid, oTuneWord, oWaveSel, oAmpSel, oEditSel, v, t, w, a, e);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Runs n idle cycles with ready high, counting transfers and keeping the last tune word seen.
  task automatic drain(input int n, output int cnt, output logic [31:0] last_tune,
                       output logic [1:0] last_wave, output logic [2:0] last_amp);
    cnt = 0; last_tune = '0; last_wave = '0; last_amp = '0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1);
      if (oCfgValid) begin
        cnt++;
        last_tune = oTuneWord;
        last_wave = oWaveSel;
        last_amp  = oAmpSel;
      end
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] lt;
    logic [1:0]  lw;
    logic [2:0]  la;

    n_pass = 0; n_total = 0;
    RESETn = 1'b0;
    iBtnMode = 0; iBtnUp = 0; iBtnDown = 0; iCfgReady = 1;

    //      m u d r   v  tune  w a e
    add(0,0,0,1, 0,   0, 0,0,0);
    add(0,0,0,1, 1, 179, 0,7,0);
    add(0,0,0,1, 0, 179, 0,7,0);
    add(0,0,0,1, 0, 179, 0,7,0);
    add(0,1,0,1, 0, 179, 0,7,0);
    add(0,0,0,1, 0, 179, 0,7,0);
    add(0,0,0,1, 1, 358, 0,7,0);
    add(0,0,0,1, 0, 358, 0,7,0);
    add(0,1,0,1, 0, 358, 0,7,0);
    add(0,0,0,1, 0, 358, 0,7,0);
    add(0,0,0,1, 1, 537, 0,7,0);
    add(0,0,0,1, 0, 537, 0,7,0);
    add(1,0,0,0, 0, 537, 0,7,1);
    add(0,1,0,0, 0, 537, 0,7,1);
    add(0,0,0,0, 0, 537, 0,7,1);
    add(0,0,0,0, 1, 537, 0,7,1);
    add(0,1,0,0, 1, 537, 0,7,1);
    add(0,0,0,0, 1, 537, 0,7,1);
    add(0,0,0,1, 0, 537, 0,7,1);
    add(0,0,0,1, 0, 537, 0,7,1);
    add(0,0,0,1, 1, 537, 0,7,1);
    add(0,0,0,1, 0, 537, 0,7,1);
    add(0,0,1,1, 0, 537, 0,7,1);
    add(0,0,0,1, 0, 537, 0,7,1);
    add(0,0,0,1, 1, 537, 0,6,1);
    add(0,0,0,1, 0, 537, 0,6,1);
    add(1,0,0,1, 0, 537, 0,6,2);
    add(0,0,1,1, 0, 537, 0,6,2);
    add(0,0,0,1, 0, 537, 0,6,2);
    add(0,0,0,1, 1, 537, 3,6,2);
    add(0,0,0,1, 0, 537, 3,6,2);
    add(0,1,0,1, 0, 537, 3,6,2);
    add(0,0,0,1, 0, 537, 3,6,2);
    add(0,0,0,1, 1, 537, 0,6,2);
    add(0,0,0,1, 0, 537, 0,6,2);
    add(1,1,0,1, 0, 537, 0,6,0);
    add(0,1,1,1, 0, 537, 0,6,0);
    add(0,0,0,1, 0, 537, 0,6,0);
    add(0,0,0,1, 0, 537, 0,6,0);
    add(0,0,0,1, 0, 537, 0,6,0);
    add(0,1,0,1, 0, 537, 0,6,0);
    add(0,0,0,1, 0, 537, 0,6,0);
    add(0,0,0,1, 1, 716, 0,6,0);
    add(0,0,0,1, 0, 716, 0,6,0);

    repeat (3) @(negedge CLK);
    check_all("reset_state", 0, 0, 0, 0, 0);
    RESETn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].m, vecs[i].u, vecs[i].d, vecs[i].r);
      check_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].tune, vecs[i].wave, vecs[i].amp, vecs[i].edit);
    end

    // Edits during VALID must not disturb the in-flight word and must coalesce.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_all("inflight_launch", 1, 895, 0, 6, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    check_all("inflight_hold", 1, 895, 0, 6, 0);
    step(0, 0, 0, 1);
    check_all("inflight_accept", 0, 895, 0, 6, 0);
    drain(10, cnt, lt, lw, la);
    check_int("coalesce_count", cnt, 1);
    check_int("coalesce_tune", int'(lt), 8 * 179);

    // Asynchronous reset while a transfer is pending.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_all("pre_reset_valid", 1, 9 * 179, 0, 6, 0);
    #2 RESETn = 1'b0;
    #1 check_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    drain(8, cnt, lt, lw, la);
    check_int("rst_retx_count", cnt, 1);
    check_int("rst_retx_tune", int'(lt), 179);
    check_int("rst_retx_wave", int'(lw), 0);
    check_int("rst_retx_amp", int'(la), 7);

    // Low frequency bound: DOWN at 1 holds 1 but still retransfers.
    step(0, 0, 1, 1);
    drain(6, cnt, lt, lw, la);
    check_int("sat_low_count", cnt, 1);
    check_int("sat_low_tune", int'(lt), 179);

    // High frequency bound.
    for (int i = 0; i < 1005; i++) step(0, 1, 0, 1);
    drain(8, cnt, lt, lw, la);
    check_all("sat_high", 0, 1000 * 179, 0, 7, 0);
    step(0, 0, 1, 1);
    drain(6, cnt, lt, lw, la);
    check_int("sat_high_down_count", cnt, 1);
    check_int("sat_high_down_tune", int'(lt), 999 * 179);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
